// File: rtl/round_key_store_pkg.sv
// Shared constants and state encoding for the round-key store.
// Imported by the round-key register file and the store top.
package round_key_store_pkg;

  localparam int KEY_SIZE_D = 128;
  localparam int ROUND_D    = 5;
  localparam int IDX_W_D    = $clog2(ROUND_D + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    READY = 2'd2
  } state_t;

endpackage

// File: rtl/round_key_regfile.sv
// Round-key storage: one sync write port, one registered read port.
// Gated reads return zero; i_clr wipes every entry in one cycle.
module round_key_regfile
  import round_key_store_pkg::*;
#(
  parameter int KEY_SIZE = KEY_SIZE_D,
  parameter int ROUND    = ROUND_D,
  parameter int IDX_W    = IDX_W_D
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                i_clr,
  input  logic                i_wr_en,
  input  logic [IDX_W-1:0]    i_wr_addr,
  input  logic [KEY_SIZE-1:0] i_wr_data,
  input  logic                i_rd_en,
  input  logic                i_rd_ok,
  input  logic [IDX_W-1:0]    i_rd_addr,
  output logic [KEY_SIZE-1:0] o_rd_data
);

  logic [KEY_SIZE-1:0] r_mem [ROUND];
  logic [KEY_SIZE-1:0] r_rd_data;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < ROUND; i++) begin
        r_mem[i] <= '0;
      end
    end else if (i_clr) begin
      for (int i = 0; i < ROUND; i++) begin
        r_mem[i] <= '0;
      end
    end else if (i_wr_en) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
  end

  // i_rd_ok already covers range, readiness and same-cycle start
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rd_data <= '0;
    end else if (i_rd_en && i_rd_ok) begin
      r_rd_data <= r_mem[i_rd_addr];
    end else begin
      r_rd_data <= '0;
    end
  end

  assign o_rd_data = r_rd_data;

endmodule

// File: rtl/round_key_store.sv
// Captures a round-key schedule, verifies its length, serves indexed reads.
// Define ROUND_KEY_DIGEST_EN to add the XOR-fold key_digest output.
module round_key_store
  import round_key_store_pkg::*;
#(
  parameter int KEY_SIZE = KEY_SIZE_D,
  parameter int ROUND    = ROUND_D,
  parameter int IDX_W    = IDX_W_D
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                start,
  input  logic                key_valid,
  input  logic [KEY_SIZE-1:0] key_in,
  input  logic                done_key,
  input  logic                rd_en,
  input  logic [IDX_W-1:0]    rd_idx,
  output logic                rd_valid,
  output logic [KEY_SIZE-1:0] rd_key,
  output logic                keys_ready,
  output logic                sched_err,
  output logic [KEY_SIZE-1:0] key_digest
);

  localparam logic [IDX_W-1:0] LP_ROUND = IDX_W'(ROUND);

  state_t           r_state;
  state_t           w_state_n;
  logic [IDX_W-1:0] r_wptr;
  logic [IDX_W-1:0] w_wptr_n;
  logic             r_keys_ready;
  logic             w_keys_ready_n;
  logic             r_sched_err;
  logic             w_sched_err_n;
  logic             r_rd_valid;
  logic             w_wr;
  logic             w_rd_ok;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= IDLE;
      r_wptr       <= '0;
      r_keys_ready <= 1'b0;
      r_sched_err  <= 1'b0;
      r_rd_valid   <= 1'b0;
    end else begin
      r_state      <= w_state_n;
      r_wptr       <= w_wptr_n;
      r_keys_ready <= w_keys_ready_n;
      r_sched_err  <= w_sched_err_n;
      r_rd_valid   <= rd_en;
    end
  end

  always_comb begin
    w_state_n      = r_state;
    w_wptr_n       = r_wptr;
    w_keys_ready_n = r_keys_ready;
    w_sched_err_n  = r_sched_err;
    w_wr           = 1'b0;
    if (start) begin
      w_state_n      = FILL;
      w_wptr_n       = '0;
      w_keys_ready_n = 1'b0;
      w_sched_err_n  = 1'b0;
    end else begin
      unique case (r_state)
        FILL: begin
          if (key_valid) begin
            if (r_wptr < LP_ROUND) begin
              w_wr     = 1'b1;
              w_wptr_n = r_wptr + IDX_W'(1);
            end else begin
              w_sched_err_n = 1'b1;
            end
          end
          // done_key judged against the count including this cycle's key
          if (done_key) begin
            if (w_wptr_n == LP_ROUND && !w_sched_err_n) begin
              w_state_n      = READY;
              w_keys_ready_n = 1'b1;
            end else begin
              w_state_n     = IDLE;
              w_sched_err_n = 1'b1;
            end
          end
        end
        READY: begin
          if (key_valid || done_key) begin
            w_state_n      = IDLE;
            w_keys_ready_n = 1'b0;
            w_sched_err_n  = 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign w_rd_ok = r_keys_ready && !start && (rd_idx < LP_ROUND);

  round_key_regfile #(
    .KEY_SIZE (KEY_SIZE),
    .ROUND    (ROUND),
    .IDX_W    (IDX_W)
  ) u_regfile (
    .clk       (clk),
    .reset_n   (reset_n),
    .i_clr     (start),
    .i_wr_en   (w_wr),
    .i_wr_addr (r_wptr),
    .i_wr_data (key_in),
    .i_rd_en   (rd_en),
    .i_rd_ok   (w_rd_ok),
    .i_rd_addr (rd_idx),
    .o_rd_data (rd_key)
  );

  assign rd_valid   = r_rd_valid;
  assign keys_ready = r_keys_ready;
  assign sched_err  = r_sched_err;

`ifdef ROUND_KEY_DIGEST_EN
  logic [KEY_SIZE-1:0] r_digest;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_digest <= '0;
    end else if (start) begin
      r_digest <= '0;
    end else if (w_wr) begin
      r_digest <= r_digest ^ key_in;
    end
  end

  assign key_digest = r_keys_ready ? r_digest : '0;
`else
  assign key_digest = '0;
`endif

endmodule

// File: tb/tb_round_key_store.sv
// Directed self-checking bench for round_key_store.
// Expected digest values depend on ROUND_KEY_DIGEST_EN.
module tb_round_key_store;

  logic         clk;
  logic         reset_n;
  logic         start;
  logic         key_valid;
  logic [127:0] key_in;
  logic         done_key;
  logic         rd_en;
  logic [2:0]   rd_idx;
  logic         rd_valid;
  logic [127:0] rd_key;
  logic         keys_ready;
  logic         sched_err;
  logic [127:0] key_digest;

  int n_tot  = 0;
  int n_pass = 0;

  logic [127:0] k1 [5];
  logic [127:0] k2 [5];
  logic [127:0] exp_dig;

  round_key_store dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .start      (start),
    .key_valid  (key_valid),
    .key_in     (key_in),
    .done_key   (done_key),
    .rd_en      (rd_en),
    .rd_idx     (rd_idx),
    .rd_valid   (rd_valid),
    .rd_key     (rd_key),
    .keys_ready (keys_ready),
    .sched_err  (sched_err),
    .key_digest (key_digest)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs,
                     input logic [127:0] exp);
    n_tot++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic do_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic put_key(input logic [127:0] k);
    key_valid = 1'b1;
    key_in    = k;
    step();
    key_valid = 1'b0;
    key_in    = '0;
  endtask

  task automatic do_done();
    done_key = 1'b1;
    step();
    done_key = 1'b0;
  endtask

  task automatic rd(input logic [2:0] idx, input logic [127:0] exp,
                    input string tag);
    rd_en  = 1'b1;
    rd_idx = idx;
    step();
    rd_en  = 1'b0;
    chk({tag, "_valid"}, {127'd0, rd_valid}, 128'd1);
    chk({tag, "_key"}, rd_key, exp);
  endtask

  initial begin
    for (int i = 0; i < 5; i++) begin
      k1[i] = {16{8'((i + 1) * 8'h11)}};
      k2[i] = {16{8'(8'hC1 + i)}};
    end
    reset_n   = 1'b0;
    start     = 1'b0;
    key_valid = 1'b0;
    key_in    = '0;
    done_key  = 1'b0;
    rd_en     = 1'b0;
    rd_idx    = '0;
    repeat (3) step();
    chk("rst_ready", {127'd0, keys_ready}, 128'd0);
    chk("rst_err", {127'd0, sched_err}, 128'd0);
    chk("rst_rdv", {127'd0, rd_valid}, 128'd0);
    chk("rst_rdkey", rd_key, 128'd0);
    chk("rst_dig", key_digest, 128'd0);
    reset_n = 1'b1;
    step();

    // nominal fill and readback
    do_start();
    for (int i = 0; i < 5; i++) put_key(k1[i]);
    chk("nom_notready", {127'd0, keys_ready}, 128'd0);
    do_done();
    chk("nom_ready", {127'd0, keys_ready}, 128'd1);
    chk("nom_err", {127'd0, sched_err}, 128'd0);
`ifdef ROUND_KEY_DIGEST_EN
    exp_dig = {16{8'h11}};
`else
    exp_dig = '0;
`endif
    chk("nom_dig", key_digest, exp_dig);
    for (int i = 0; i < 5; i++) rd(3'(i), k1[i], $sformatf("nom_rd%0d", i));
    step();
    chk("nom_rdv_drop", {127'd0, rd_valid}, 128'd0);

    // out-of-range reads, stored keys untouched
    rd(3'd5, 128'd0, "oor5");
    rd(3'd7, 128'd0, "oor7");
    rd(3'd2, k1[2], "oor_keep");

    // stale key in READY
    put_key(k1[0]);
    chk("stale_err", {127'd0, sched_err}, 128'd1);
    chk("stale_ready", {127'd0, keys_ready}, 128'd0);

    // digest keys 1,2,4,8,16
    do_start();
    chk("dig_start_err", {127'd0, sched_err}, 128'd0);
    for (int i = 0; i < 5; i++) put_key(128'(1) << i);
    do_done();
    chk("dig_ready", {127'd0, keys_ready}, 128'd1);
`ifdef ROUND_KEY_DIGEST_EN
    exp_dig = 128'h1F;
`else
    exp_dig = '0;
`endif
    chk("dig_val", key_digest, exp_dig);
    rd(3'd4, 128'h10, "dig_rd4");

    // read in same cycle as start returns zero
    start  = 1'b1;
    rd_en  = 1'b1;
    rd_idx = 3'd0;
    step();
    start = 1'b0;
    rd_en = 1'b0;
    chk("st_rd_valid", {127'd0, rd_valid}, 128'd1);
    chk("st_rd_key", rd_key, 128'd0);
    chk("st_dig", key_digest, 128'd0);
    chk("st_ready", {127'd0, keys_ready}, 128'd0);

    // short schedule
    for (int i = 0; i < 3; i++) put_key(k1[i]);
    do_done();
    chk("short_err", {127'd0, sched_err}, 128'd1);
    chk("short_ready", {127'd0, keys_ready}, 128'd0);
    rd(3'd0, 128'd0, "short_rd");
    put_key(k1[0]);
    chk("short_idle_ready", {127'd0, keys_ready}, 128'd0);

    // overflow
    do_start();
    chk("ovf_start_clr", {127'd0, sched_err}, 128'd0);
    for (int i = 0; i < 5; i++) put_key(k1[i]);
    chk("ovf_pre_err", {127'd0, sched_err}, 128'd0);
    put_key({16{8'h66}});
    chk("ovf_err", {127'd0, sched_err}, 128'd1);
    do_done();
    chk("ovf_err2", {127'd0, sched_err}, 128'd1);
    chk("ovf_ready", {127'd0, keys_ready}, 128'd0);
    do_start();
    chk("ovf_clr", {127'd0, sched_err}, 128'd0);

    // reset mid-fill with a read in flight
    put_key({16{8'hAA}});
    rd_en  = 1'b1;
    rd_idx = 3'd0;
    put_key({16{8'hBB}});
    rd_en = 1'b0;
    chk("mid_rdv", {127'd0, rd_valid}, 128'd1);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_rdv", {127'd0, rd_valid}, 128'd0);
    chk("mid_rst_ready", {127'd0, keys_ready}, 128'd0);
    chk("mid_rst_err", {127'd0, sched_err}, 128'd0);
    chk("mid_rst_dig", key_digest, 128'd0);
    step();
    reset_n = 1'b1;
    step();

    // new schedule, last key together with done_key
    do_start();
    for (int i = 0; i < 4; i++) put_key(k2[i]);
    key_valid = 1'b1;
    key_in    = k2[4];
    done_key  = 1'b1;
    step();
    key_valid = 1'b0;
    done_key  = 1'b0;
    chk("new_ready", {127'd0, keys_ready}, 128'd1);
    chk("new_err", {127'd0, sched_err}, 128'd0);
    for (int i = 0; i < 5; i++) rd(3'(i), k2[i], $sformatf("new_rd%0d", i));

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
